// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Field widths of the struct types follow the default geometry.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] wa;
    logic [DATA_W_DEF-1:0] wd;
  } wr_port_t;

  function automatic logic nz_hit(
    input logic en,
    input logic [31:0] a
  );
    return en && (a != 32'd0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// Per-register busy bits with set/clear arbitration
// and an incrementally maintained busy population count.
module regfile_scoreboard_busy
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [ADDR_W:0]   cnt_o
);

  localparam int CW = ADDR_W + 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                set_v, clr_v, inc, dec;

  assign set_v = set_en_i && (set_addr_i != '0);
  assign clr_v = clr_en_i && (clr_addr_i != '0);

  always_comb begin
    busy_d = busy_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (clr_v) busy_d[clr_addr_i] = 1'b0;
    // A new reservation on the retiring register survives the writeback
    if (set_v) busy_d[set_addr_i] = 1'b1;
    inc = set_v && !busy_q[set_addr_i];
    dec = clr_v && busy_q[clr_addr_i]
        && !(set_v && (set_addr_i == clr_addr_i));
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with two write ports, write-to-read
// bypass and a busy scoreboard for long-latency results.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 3,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     res_en,
  input  logic [ADDR_W-1:0]        res_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     wr_conflict
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wp_t;

  wp_t w0, w1;
  logic w0_v, w1_v;
  logic conflict_q, conflict_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  assign w0 = '{we: we0, wa: wa0, wd: wd0};
  assign w1 = '{we: we1, wa: wa1, wd: wd1};

  assign w0_v = nz_hit(w0.we, 32'(w0.wa));
  assign w1_v = nz_hit(w1.we, 32'(w1.wa));

  assign conflict_d = w0_v && w1_v && (w0.wa == w1.wa);

  // WP1 is written last so it wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (w0_v) mem_q[w0.wa] <= w0.wd;
      if (w1_v) mem_q[w1.wa] <= w1.wd;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              w1_hit;

    assign a      = rd_addr[i*ADDR_W +: ADDR_W];
    assign w1_hit = w1.we && (w1.wa == a);

    always_comb begin
      d = mem_q[a];
      if (rst || (a == '0))      d = '0;
      else if (w1_hit)           d = w1.wd;
      else if (w0.we && (w0.wa == a)) d = w0.wd;
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_ready[i] = (a == '0) || !busy[a] || w1_hit;
  end

  regfile_scoreboard_busy #(
    .NUM_REGS(NUM_REGS)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (res_en),
    .set_addr_i(res_addr),
    .clr_en_i  (we1),
    .clr_addr_i(wa1),
    .busy_o    (busy),
    .cnt_o     (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed checks of regfile_scoreboard
// against a behavioural model of the register file.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int NRD = 3;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_ready;
  logic we0, we1, res_en;
  reg_addr_t wa0, wa1, res_addr;
  logic [DW-1:0] wd0, wd1;
  logic [AW:0] busy_cnt;
  logic wr_conflict;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg [NR];
  bit            m_busy[NR];
  bit            m_conf;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .res_en(res_en), .res_addr(res_addr),
    .busy_cnt(busy_cnt), .wr_conflict(wr_conflict)
  );

  function automatic logic [DW-1:0] exp_rd(int a);
    if (rst || a == 0) return '0;
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic bit exp_rdy(int a);
    return a == 0 || !m_busy[a] || (we1 && int'(wa1) == a);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    foreach (m_busy[r]) n += m_busy[r];
    return n;
  endfunction

  function automatic int port_addr(int p);
    return int'(rd_addr[p*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] port_data(int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic model_clear();
    foreach (m_reg[r]) m_reg[r] = '0;
    foreach (m_busy[r]) m_busy[r] = 0;
    m_conf = 0;
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    res_en = 0; res_addr = '0;
  endtask

  task automatic set_rd(int a0, int a1, int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // Advance one edge and apply the architectural rules to the model
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      m_conf = we0 && we1 && wa0 == wa1 && wa0 != 0;
      if (we0 && wa0 != 0) m_reg[wa0] = wd0;
      if (we1 && wa1 != 0) m_reg[wa1] = wd1;
      if (we1 && wa1 != 0) m_busy[wa1] = 0;
      if (res_en && res_addr != 0) m_busy[res_addr] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle(); we0 = 1; wa0 = 5; wd0 = 32'h1234;
    res_en = 1; res_addr = 6;
    tick();
    @(negedge clk);
    idle(); set_rd(5, 6, 0);
    #2 rst = 1;
    #1 model_clear();
    checks++;
    if (port_data(0) !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5: got %h want 0", port_data(0));
    end
    checks++;
    if (busy_cnt !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", busy_cnt);
    end
    checks++;
    if (rd_ready !== 3'b111 || wr_conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy: got %b/%b want 111/0", rd_ready, wr_conflict);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_r0();
    @(negedge clk);
    idle(); set_rd(0, 0, 0);
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
    res_en = 1; res_addr = 0;
    tick();
    @(negedge clk);
    idle(); #1;
    checks++;
    if (port_data(0) !== 32'h0 || rd_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL r0: got %h/%b want 0/1", port_data(0), rd_ready[0]);
    end
    checks++;
    if (busy_cnt !== 0) begin
      errors++;
      $display("FAIL r0_cnt: got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle(); set_rd(3, 0, 0);
    we0 = 1; wa0 = 3; wd0 = 32'hAAAA;
    we1 = 1; wa1 = 3; wd1 = 32'h5555;
    #1;
    checks++;
    if (port_data(0) !== 32'h5555) begin
      errors++;
      $display("FAIL coll_bypass: got %h want 5555", port_data(0));
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b1) begin
      errors++;
      $display("FAIL coll_flag: got %b want 1", wr_conflict);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (port_data(0) !== 32'h5555) begin
      errors++;
      $display("FAIL coll_store: got %h want 5555", port_data(0));
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++;
      $display("FAIL coll_pulse: got %b want 0", wr_conflict);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle(); res_en = 1; res_addr = 7;
    tick();
    @(negedge clk);
    idle(); set_rd(7, 0, 0); #1;
    checks++;
    if (rd_ready[0] !== 1'b0 || busy_cnt !== 1) begin
      errors++;
      $display("FAIL sb_busy: got %b/%0d want 0/1", rd_ready[0], busy_cnt);
    end
    @(negedge clk);
    we1 = 1; wa1 = 7; wd1 = 32'hBEEF; #1;
    checks++;
    if (rd_ready[0] !== 1'b1 || port_data(0) !== 32'hBEEF) begin
      errors++;
      $display("FAIL sb_wb: got %b/%h want 1/beef", rd_ready[0], port_data(0));
    end
    tick();
    checks++;
    if (busy_cnt !== 0) begin
      errors++;
      $display("FAIL sb_clear: got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_race();
    @(negedge clk);
    idle(); res_en = 1; res_addr = 9;
    tick();
    @(negedge clk);
    res_en = 1; res_addr = 9;
    we1 = 1; wa1 = 9; wd1 = 32'h42;
    tick();
    @(negedge clk);
    idle(); set_rd(9, 0, 0); #1;
    checks++;
    if (port_data(0) !== 32'h42 || rd_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL race: got %h/%b want 42/0", port_data(0), rd_ready[0]);
    end
    checks++;
    if (busy_cnt !== 1) begin
      errors++;
      $display("FAIL race_cnt: got %0d want 1", busy_cnt);
    end
  endtask

  task automatic test_fill_reset();
    for (int r = 1; r < NR; r++) begin
      @(negedge clk);
      idle(); res_en = 1; res_addr = reg_addr_t'(r);
      tick();
    end
    checks++;
    if (busy_cnt !== 15) begin
      errors++;
      $display("FAIL fill: got %0d want 15", busy_cnt);
    end
    @(negedge clk);
    idle(); set_rd(1, 8, 15);
    #2 rst = 1;
    #1 model_clear();
    checks++;
    if (busy_cnt !== 0 || rd_ready !== 3'b111) begin
      errors++;
      $display("FAIL fill_rst: got %0d/%b want 0/111", busy_cnt, rd_ready);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we0 = 1'($urandom); wa0 = reg_addr_t'($urandom); wd0 = $urandom;
      we1 = 1'($urandom); wa1 = reg_addr_t'($urandom); wd1 = $urandom;
      if ($urandom_range(3) == 0) wa1 = wa0;
      res_en = ($urandom_range(2) != 0);
      res_addr = reg_addr_t'($urandom);
      if ($urandom_range(4) == 0) res_addr = wa1;
      set_rd($urandom_range(15), $urandom_range(15), int'(wa1));
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (port_data(p) !== exp_rd(port_addr(p))
            || rd_ready[p] !== exp_rdy(port_addr(p))) begin
          errors++;
          $display("FAIL rand_rd%0d a=%0d: got %h/%b want %h/%b", p,
                   port_addr(p), port_data(p), rd_ready[p],
                   exp_rd(port_addr(p)), exp_rdy(port_addr(p)));
        end
      end
      tick();
      checks++;
      if (busy_cnt !== (AW+1)'(exp_cnt()) || wr_conflict !== m_conf) begin
        errors++;
        $display("FAIL rand_reg: got %0d/%b want %0d/%b",
                 busy_cnt, wr_conflict, exp_cnt(), m_conf);
      end
    end
  endtask

  initial begin
    rst = 1;
    idle();
    set_rd(0, 0, 0);
    model_clear();
    #12 rst = 0;
    test_reset();
    test_r0();
    test_collision();
    test_scoreboard();
    test_race();
    test_fill_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-port register file for the POC processor datapath, successor to the fixed 16x32, 3-read, 1-write file.
- Adds:
  - configurable width, depth and read-port count;
  - two write ports: WP0 for ALU writeback, WP1 for memory/long-latency writeback;
  - same-cycle write-to-read bypass;
  - a per-register busy scoreboard, so decode can stall on pending long-latency results.
- Sits between decode (reads, reservations) and the writeback stages.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers; power of two, minimum 4.
- NUM_RD, 3, number of read ports.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same slicing as rd_addr.
- rd_ready  out  NUM_RD  per-port operand-available flag.
- we0  in  1  WP0 write enable.
- wa0  in  ADDR_W  WP0 write address.
- wd0  in  DATA_W  WP0 write data.
- we1  in  1  WP1 write enable; also clears busy for its address.
- wa1  in  ADDR_W  WP1 write address.
- wd1  in  DATA_W  WP1 write data.
- res_en  in  1  reserve request: mark res_addr busy.
- res_addr  in  ADDR_W  register to reserve.
- busy_cnt  out  ADDR_W+1  number of busy registers.
- wr_conflict  out  1  registered one-cycle pulse: WP0 and WP1 wrote the same non-zero address in the previous cycle.

Behaviour:
- Reset (async, rst high):
  - all registers, the busy vector, busy_cnt and wr_conflict go to 0 immediately.
  - rd_data reads 0 for every address; rd_ready is all 1.
  - Reset asserted mid-operation discards any in-flight reservations.
- Register 0:
  - always reads 0 and always reports ready;
  - writes to address 0 on either port are ignored;
  - res_en with res_addr=0 is ignored (busy_cnt unchanged).
- Writes: registered on posedge clk.
  - WP0 writes wd0 when we0 is high and wa0 != 0.
  - WP1 writes wd1 when we1 is high and wa1 != 0.
  - If both write the same non-zero address in one cycle, WP1 wins.
  - In that collision case wr_conflict is 1 in the following cycle, otherwise 0.
- Reads: combinational, zero latency, priority per port:
  1. address 0 -> 0;
  2. we1 and wa1 match -> wd1;
  3. we0 and wa0 match -> wd0;
  4. otherwise the stored value.
- Scoreboard: one busy bit per register, updated on posedge clk.
  - Set: res_en and res_addr != 0.
  - Clear: we1 and wa1 != 0 clears busy[wa1].
  - Set and clear on the same address in the same cycle: set wins (new reservation follows writeback).
  - WP0 never touches busy bits.
  - Reserving an already-busy register keeps it busy; there is no nesting count.
- rd_ready[i] = (rd_addr_i == 0) OR NOT busy[rd_addr_i] OR (we1 AND wa1 == rd_addr_i).
  - A same-cycle WP1 writeback makes the operand ready via bypass.
- busy_cnt is registered and always equals the popcount of the busy vector after the edge.
  - It is updated incrementally: +1, -1, or 0 per cycle, with set/clear interactions resolved as above.
  - Maximum value is NUM_REGS-1 (register 0 can never be busy).

Decomposition:
- Package regfile_pkg holds:
  - localparam defaults DATA_W_DEF=32, NUM_REGS_DEF=16;
  - typedef reg_addr_t (logic [ADDR_W-1:0]);
  - typedef wr_port_t, a struct {we, wa, wd}.
- One sub-module, regfile_scoreboard_busy, holds the busy vector, the set/clear arbitration and the busy_cnt counter.
- Storage array, write logic and the bypass/read muxes stay in the top module.

Test Plan:
- Reset: hold rst, pre-write R5=0x1234 beforehand -> after async rst, rd_data of R5 = 0, busy_cnt = 0, rd_ready = all 1.
- R0 protection: we0=1, wa0=0, wd0=0xFFFFFFFF; res_en=1, res_addr=0 -> rd of R0 = 0, rd_ready = 1, busy_cnt = 0.
- Bypass and collision: we0 writes R3=0xAAAA and we1 writes R3=0x5555 in the same cycle -> same-cycle read of R3 = 0x5555; next cycle stored R3 = 0x5555 and wr_conflict = 1 for one cycle.
- Scoreboard: reserve R7 -> next cycle rd_ready(R7) = 0, busy_cnt = 1. Then we1 writes R7=0xBEEF -> rd_ready = 1 that same cycle with rd_data = 0xBEEF; after the edge busy_cnt = 0.
- Set/clear race: with R9 busy, apply res_en R9 and we1 R9=0x42 in the same cycle -> R9 stores 0x42, stays busy, busy_cnt unchanged.
- Fill: reserve R1..R15 on consecutive cycles -> busy_cnt reaches 15. Then apply rst mid-sequence -> busy_cnt = 0 immediately.
